// File: rtl/bus_pkg.sv
// Shared types and constants for the bus memory responder: FSM states,
// tag decoding and cache-line geometry.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LAT   = 2'd1,
        RESP  = 2'd2,
        WDATA = 2'd3
    } bus_state_t;

    localparam int TAG_READ_BIT     = 12;
    localparam int BEATS_PER_LINE   = 8;
    localparam int LINE_WIDTH       = 512;
    localparam int LINE_OFFSET_BITS = 6;

    function automatic logic is_last_beat(input logic [2:0] cnt);
        return cnt == 3'(BEATS_PER_LINE - 1);
    endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Backing store: one registered full-line read port and one full-line write
// port. Not reset, so contents survive a responder reset.
module bus_mem_array
    import bus_pkg::*;
#(
    parameter int LINE_BITS  = LINE_WIDTH,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [LINE_BITS-1:0]  rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [LINE_BITS-1:0]  wr_data
);

    logic [LINE_BITS-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Line-oriented memory responder: 8-beat read bursts after a fixed latency,
// 8-beat write collection. Define BUS_MEM_WRITE_EN to commit writes to the store.
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LOG_MEM_LINES  = 6,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int LINE_BITS = BEATS_PER_LINE * BUS_DATA_WIDTH;
    localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

`ifdef BUS_MEM_WRITE_EN
    localparam bit WRITE_COMMIT = 1'b1;
`else
    localparam bit WRITE_COMMIT = 1'b0;
`endif

    bus_state_t state_reg, state_next;

    logic [2:0]                cnt_reg, cnt_next;
    logic [3:0]                lat_reg, lat_next;
    logic [BUS_TAG_WIDTH-1:0]  tag_reg, tag_next;
    logic [LOG_MEM_LINES-1:0]  line_reg, line_next;
    logic [LINE_BITS-1:0]      wline_reg, wline_next;
    logic                      reqack_reg, reqack_next;
    logic                      respcyc_reg, respcyc_next;
    logic [BUS_DATA_WIDTH-1:0] resp_reg, resp_next;
    logic [BUS_TAG_WIDTH-1:0]  resptag_reg, resptag_next;

    logic [LOG_MEM_LINES-1:0]  mem_rd_addr;
    logic [LINE_BITS-1:0]      mem_rd_data;
    logic                      mem_wr_en;
    logic [BUS_DATA_WIDTH-1:0] rd_beat [BEATS_PER_LINE];

    logic                      req_take;
    logic                      beat_take;
    logic                      resp_acked;
    logic                      last_beat;
    logic [LOG_MEM_LINES-1:0]  req_index;

    // A cycle that already shows reqack is never a new request or beat, which
    // keeps acks at least one cycle apart.
    assign req_take   = bus_reqcyc && !reqack_reg;
    assign beat_take  = (state_reg == WDATA) && req_take;
    assign resp_acked = (state_reg == RESP) && respcyc_reg && bus_respack;
    assign last_beat  = is_last_beat(cnt_reg);
    assign req_index  = bus_req[LINE_OFFSET_BITS +: LOG_MEM_LINES];

    // Reading straight from the request address lets a latency of 1 still
    // have the line ready when the first beat is due.
    assign mem_rd_addr = (state_reg == IDLE) ? req_index : line_reg;

    generate
        for (genvar gi = 0; gi < BEATS_PER_LINE; gi++) begin : g_beat
            assign rd_beat[gi] = mem_rd_data[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            assign wline_next[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] =
                (beat_take && (cnt_reg == 3'(gi))) ? bus_req
                                                   : wline_reg[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        end
    endgenerate

    bus_mem_array #(
        .LINE_BITS  (LINE_BITS),
        .ADDR_WIDTH (LOG_MEM_LINES)
    ) u_mem (
        .clk     (clk),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_data),
        .wr_en   (mem_wr_en),
        .wr_addr (line_reg),
        .wr_data (wline_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_take) begin
                    state_next = bus_reqtag[TAG_READ_BIT] ? LAT : WDATA;
                end
            end
            LAT: begin
                if (lat_reg == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_acked && last_beat) begin
                    state_next = IDLE;
                end
            end
            WDATA: begin
                if (beat_take && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next     = cnt_reg;
        lat_next     = lat_reg;
        tag_next     = tag_reg;
        line_next    = line_reg;
        reqack_next  = 1'b0;
        respcyc_next = respcyc_reg;
        resp_next    = resp_reg;
        resptag_next = resptag_reg;
        mem_wr_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_take) begin
                    reqack_next = 1'b1;
                    tag_next    = bus_reqtag;
                    line_next   = req_index;
                    cnt_next    = 3'd0;
                    lat_next    = LAT_INIT;
                end
            end
            LAT: begin
                if (lat_reg == 4'd0) begin
                    respcyc_next = 1'b1;
                    resp_next    = rd_beat[cnt_reg];
                    resptag_next = tag_reg;
                end else begin
                    lat_next = lat_reg - 4'd1;
                end
            end
            RESP: begin
                if (resp_acked) begin
                    cnt_next = cnt_reg + 3'd1;
                    if (last_beat) begin
                        respcyc_next = 1'b0;
                        resp_next    = '0;
                        resptag_next = '0;
                    end else begin
                        resp_next = rd_beat[cnt_reg + 3'd1];
                    end
                end
            end
            WDATA: begin
                if (beat_take) begin
                    reqack_next = 1'b1;
                    cnt_next    = cnt_reg + 3'd1;
                    mem_wr_en   = WRITE_COMMIT && last_beat;
                end
            end
            default: begin
                respcyc_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg     <= 3'd0;
            lat_reg     <= 4'd0;
            tag_reg     <= '0;
            line_reg    <= '0;
            wline_reg   <= '0;
            reqack_reg  <= 1'b0;
            respcyc_reg <= 1'b0;
            resp_reg    <= '0;
            resptag_reg <= '0;
        end else begin
            cnt_reg     <= cnt_next;
            lat_reg     <= lat_next;
            tag_reg     <= tag_next;
            line_reg    <= line_next;
            wline_reg   <= wline_next;
            reqack_reg  <= reqack_next;
            respcyc_reg <= respcyc_next;
            resp_reg    <= resp_next;
            resptag_reg <= resptag_next;
        end
    end

    assign bus_reqack  = reqack_reg;
    assign bus_respcyc = respcyc_reg;
    assign bus_resp    = resp_reg;
    assign bus_resptag = resptag_reg;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: reads, stalls, writes, aliasing,
// reset abort and requests arriving during a response burst.
module tb_bus_mem_responder;

    localparam int DW  = 64;
    localparam int TW  = 13;
    localparam int LML = 6;
    localparam int LAT = 4;

`ifdef BUS_MEM_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t         exp_q[$];
    logic [511:0] model [0:(1<<LML)-1];
    int           checks;
    int           errors;

    bus_mem_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .LOG_MEM_LINES  (LML),
        .READ_LATENCY   (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] make_line(input logic [63:0] base);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
        return l;
    endfunction

    task automatic check_outputs_zero(input string name);
        checks++;
        if (bus_reqack !== 1'b0 || bus_respcyc !== 1'b0 || bus_resp !== '0 || bus_resptag !== '0) begin
            errors++;
            $display("FAIL %s: reqack=%b respcyc=%b resp=%h resptag=%h, required all zero",
                     name, bus_reqack, bus_respcyc, bus_resp, bus_resptag);
        end
    endtask

    // Presents a request from IDLE and expects the ack exactly one cycle later.
    task automatic issue_req(input logic [DW-1:0] addr, input logic [TW-1:0] tag);
        int n;
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = tag;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus_reqack && n < 20);
        checks++;
        if (bus_reqack !== 1'b1 || n != 1) begin
            errors++;
            $display("FAIL req_accept: reqack=%b after %0d cycles, required 1 after 1 cycle", bus_reqack, n);
        end
        $display("req addr=%h tag=%h acked after %0d cycles", addr, tag, n);
        bus_reqcyc = 1'b0;
    endtask

    // Called in the reqack cycle; consumes beats until stop_beat (8 = whole line).
    task automatic collect_read(input int idx, input logic [TW-1:0] tag, input int stall_beat,
                                input int stall_cycles, input bit watch_reqack, input int stop_beat);
        exp_t e;
        int   n;
        for (int b = 0; b < 8; b++) begin
            e.data = model[idx][b*DW +: DW];
            e.tag  = tag;
            exp_q.push_back(e);
        end
        bus_respack = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) begin
                checks++;
                if (bus_reqack !== 1'b0) begin
                    errors++;
                    $display("FAIL reqack_pulse: reqack=%b in cycle after ack, required 0", bus_reqack);
                end
            end
        end while (!bus_respcyc && n < 40);
        checks++;
        if (bus_respcyc !== 1'b1 || n != LAT) begin
            errors++;
            $display("FAIL read_latency: respcyc=%b after %0d cycles, required 1 after %0d", bus_respcyc, n, LAT);
        end
        if (bus_respcyc !== 1'b1) begin
            exp_q.delete();
            return;
        end
        for (int b = 0; b < 8; b++) begin
            if (b == stop_beat) return;
            e = exp_q.pop_front();
            checks++;
            if (bus_respcyc !== 1'b1 || bus_resp !== e.data || bus_resptag !== e.tag) begin
                errors++;
                $display("FAIL read_beat%0d: respcyc=%b data=%h tag=%h, required 1 data=%h tag=%h",
                         b, bus_respcyc, bus_resp, bus_resptag, e.data, e.tag);
            end
            $display("read line %0d beat %0d data=%h tag=%h", idx, b, bus_resp, bus_resptag);
            if (watch_reqack) begin
                checks++;
                if (bus_reqack !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_reqack: reqack=%b during response beat %0d, required 0", bus_reqack, b);
                end
            end
            if (b == stall_beat) begin
                bus_respack = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    step();
                    checks++;
                    if (bus_respcyc !== 1'b1 || bus_resp !== e.data || bus_resptag !== e.tag) begin
                        errors++;
                        $display("FAIL read_stall%0d: respcyc=%b data=%h tag=%h, required 1 data=%h tag=%h",
                                 s, bus_respcyc, bus_resp, bus_resptag, e.data, e.tag);
                    end
                end
                bus_respack = 1'b1;
            end
            step();
        end
        checks++;
        if (bus_respcyc !== 1'b0) begin
            errors++;
            $display("FAIL read_end: respcyc=%b after last beat acked, required 0", bus_respcyc);
        end
    endtask

    task automatic write_line(input logic [DW-1:0] addr, input logic [TW-1:0] tag, input logic [63:0] base);
        logic [511:0] line;
        int           n;
        line = make_line(base);
        issue_req(addr, tag);
        for (int b = 0; b < 8; b++) begin
            bus_reqcyc = 1'b1;
            bus_req    = line[b*DW +: DW];
            n = 0;
            do begin
                step();
                n++;
            end while (!bus_reqack && n < 20);
            checks++;
            if (bus_reqack !== 1'b1 || n != 2) begin
                errors++;
                $display("FAIL write_beat%0d: reqack=%b after %0d cycles, required 1 after 2", b, bus_reqack, n);
            end
            $display("write beat %0d data=%h acked after %0d cycles", b, bus_req, n);
        end
        bus_reqcyc = 1'b0;
        step();
        checks++;
        if (bus_reqack !== 1'b0) begin
            errors++;
            $display("FAIL write_done: reqack=%b after final beat, required 0", bus_reqack);
        end
        if (WR_EN) model[addr[6 +: LML]] = line;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        step();
        step();
        check_outputs_zero("reset_state");
        reset = 1'b0;
        step();
        check_outputs_zero("after_reset");
    endtask

    task automatic test_read_basic();
        issue_req(64'd3 * 64'h40, 13'h1100);
        collect_read(3, 13'h1100, -1, 0, 1'b0, 8);
    endtask

    task automatic test_read_stall();
        issue_req(64'd3 * 64'h40, 13'h1100);
        collect_read(3, 13'h1100, 2, 3, 1'b0, 8);
    endtask

    task automatic test_write_readback();
        write_line(64'd5 * 64'h40, 13'h0100, 64'hA0);
        issue_req(64'd5 * 64'h40, 13'h1100);
        collect_read(5, 13'h1100, -1, 0, 1'b0, 8);
    endtask

    task automatic test_alias();
        issue_req(64'd5 * 64'h40 + (64'd1 << 12), 13'h1003);
        collect_read(5, 13'h1003, -1, 0, 1'b0, 8);
    endtask

    task automatic test_reset_mid_read();
        issue_req(64'd3 * 64'h40, 13'h1100);
        collect_read(3, 13'h1100, -1, 0, 1'b0, 4);
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_mid_read");
        exp_q.delete();
        step();
        reset = 1'b0;
        step();
        issue_req(64'd3 * 64'h40, 13'h1100);
        collect_read(3, 13'h1100, -1, 0, 1'b0, 8);
    endtask

    task automatic test_req_during_resp();
        issue_req(64'd3 * 64'h40, 13'h1100);
        bus_reqcyc = 1'b1;
        bus_req    = 64'd5 * 64'h40;
        bus_reqtag = 13'h1102;
        collect_read(3, 13'h1100, -1, 0, 1'b1, 8);
        checks++;
        if (bus_reqack !== 1'b0) begin
            errors++;
            $display("FAIL busy_release: reqack=%b on return to idle, required 0", bus_reqack);
        end
        step();
        checks++;
        if (bus_reqack !== 1'b1) begin
            errors++;
            $display("FAIL late_accept: reqack=%b one cycle after idle, required 1", bus_reqack);
        end
        bus_reqcyc = 1'b0;
        collect_read(5, 13'h1102, -1, 0, 1'b0, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < (1<<LML); i++) begin
            model[i] = '0;
            dut.u_mem.mem[i] = '0;
        end
        model[3] = make_line(64'h1111_0000);
        model[5] = make_line(64'h5555_0000);
        dut.u_mem.mem[3] = model[3];
        dut.u_mem.mem[5] = model[5];

        test_reset();
        test_read_basic();
        test_read_stall();
        test_write_readback();
        test_alias();
        test_reset_mid_read();
        test_req_during_resp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64: width of request and response data beats.
REQ-002 Parameter BUS_TAG_WIDTH, default 13: transaction tag width.
REQ-003 Parameter LOG_MEM_LINES, default 6: log2 of backing-store 64-byte lines.
REQ-004 Parameter READ_LATENCY, default 4 (legal 1..15): cycles from request reqack to first response beat.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 bus_reqcyc  input  1  initiator request/write-beat valid.
REQ-008 bus_req  input  BUS_DATA_WIDTH  request line address (bits [5:0] zero) or write data beat.
REQ-009 bus_reqtag  input  BUS_TAG_WIDTH  tag; bit 12 = 1 read, 0 write.
REQ-010 bus_reqack  output  1  one-cycle acceptance pulse for request or write beat.
REQ-011 bus_respcyc  output  1  response beat valid.
REQ-012 bus_resp  output  BUS_DATA_WIDTH  response data beat.
REQ-013 bus_resptag  output  BUS_TAG_WIDTH  tag echoed from accepted request.
REQ-014 bus_respack  input  1  initiator accepts current response beat.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 States SHALL be IDLE, LAT, RESP, WDATA.
REQ-017 IDLE: bus_reqcyc=1 sampled -> bus_reqack=1 next cycle; capture tag and line index bus_req[6 +: LOG_MEM_LINES]; upper address bits SHALL be ignored (aliasing); read -> LAT, write -> WDATA; beat counter cleared.
REQ-018 bus_reqack SHALL be high exactly one cycle per accepted request or beat, never in two consecutive cycles.
REQ-019 LAT: count down; first bus_respcyc SHALL assert exactly READ_LATENCY cycles after the reqack cycle; -> RESP.
REQ-020 RESP: beat i (0..7) SHALL carry line bits [64i +: 64]; bus_respcyc, bus_resp, bus_resptag SHALL hold stable until bus_respack=1 is sampled with bus_respcyc=1, then advance one beat next cycle.
REQ-021 After beat 7 is acked, bus_respcyc SHALL drop next cycle and state SHALL return to IDLE.
REQ-022 WDATA: each bus_reqcyc=1 cycle not coinciding with bus_reqack=1 SHALL capture one beat into line bits [64i +: 64] and pulse bus_reqack; after beat 7, line SHALL be committed to the store in one write and state -> IDLE.
REQ-023 bus_reqcyc while not IDLE/WDATA SHALL be ignored (no reqack) until IDLE.
REQ-024 bus_respack without bus_respcyc SHALL be ignored.
REQ-025 Counter SHALL be 3 bits; wrap from 7 to 0 only on IDLE return.

Reset
REQ-026 Reset SHALL force IDLE immediately, all outputs 0, counters 0, captured tag 0.
REQ-027 Reset mid-transaction SHALL abort it; partially collected write beats SHALL be discarded; backing-store contents SHALL be retained (initial contents zero at elaboration).

Configuration
REQ-028 BUS_MEM_WRITE_EN defined: writes behave per REQ-022.
REQ-029 BUS_MEM_WRITE_EN undefined: write requests and all 8 beats SHALL still be acked but data SHALL be discarded; store unchanged.

Structure
REQ-030 Package bus_pkg SHALL hold the state enum, tag read-bit index (12), beats-per-line (8) and line width (512).
REQ-031 Storage SHALL be sub-module bus_mem_array: one read port, one 512-bit write port, LOG_MEM_LINES address bits.

Verification
REQ-032 Read line 3 preloaded 0..7 beat pattern 0x1111_0000+i, tag 0x1100, respack always 1 -> reqack one cycle, first respcyc 4 cycles later, 8 consecutive beats 0x11110000..0x11110007, resptag 0x1100.
REQ-033 Same read, respack held low 3 cycles on beat 2 -> beat 2 value and tag stable 3+ cycles, no beat skipped.
REQ-034 Write line 5 tag 0x0100 beats 0xA0..0xA7, then read line 5 -> read returns 0xA0..0xA7 (with BUS_MEM_WRITE_EN); returns prior contents without it.
REQ-035 Address 0x40*5 + (1<<12) with LOG_MEM_LINES=6 -> aliases line 5 (upper bits ignored).
REQ-036 Reset asserted during beat 4 of read -> outputs 0 same cycle; next read after reset completes normally with correct data.
REQ-037 bus_reqcyc asserted during RESP -> no reqack until IDLE, then accepted.
